// File: rtl/spi_word_pkg.sv
// spi_word_pkg -- shared constants and elaboration helpers for spi_word_core.
//   SYNC_STAGES      : depth of the input synchronizers (2)
//   sample_edge_e    : which spi_clk edge captures MOSI
//   sample_edge_sel  : derives the sample edge from CPOL/CPHA
//   width_legal      : WIDTH must lie in 4..32
//   depth_legal      : FIFO depth must be a power of two in 2..16
package spi_word_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic {
    EDGE_FALL = 1'b0,
    EDGE_RISE = 1'b1
  } sample_edge_e;

  // Modes 0 and 3 sample on the rising edge; modes 1 and 2 on the falling edge.
  function automatic sample_edge_e sample_edge_sel(input int unsigned cpol,
                                                   input int unsigned cpha);
    return (cpol == cpha) ? EDGE_RISE : EDGE_FALL;
  endfunction

  function automatic bit width_legal(input int unsigned w);
    return (w >= 4) && (w <= 32);
  endfunction

  function automatic bit depth_legal(input int unsigned d);
    return (d >= 2) && (d <= 16) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// spi_word_fifo -- first-word-fall-through RX FIFO for spi_word_core.
//   clk, rst_n     : system clock, synchronous active-low reset
//   push/push_data : write a completed word
//   pop_ready      : consumer ready; a pop happens when head_valid && pop_ready
//   head_data/head_valid : FIFO head (registered storage, no bypass)
//   overflow       : one-cycle pulse after a push was dropped because full
module spi_word_fifo
  import spi_word_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             overflow
);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("spi_word_fifo: DEPTH must be a power of two in 2..16");
  end

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             pop;
  logic             wr_en;

  // Pointers carry one extra bit so full and empty stay distinguishable;
  // storage is addressed by the low bits, i.e. modulo DEPTH.
  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign pop        = !empty && pop_ready;
  assign wr_en      = push && (!full || pop);
  assign head_data  = mem[rd_ptr[AW-1:0]];
  assign head_valid = !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem      <= '{default: '0};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      overflow <= push && full && !pop;
    end
  end

endmodule

// File: rtl/spi_word_core.sv
// spi_word_core -- oversampled SPI slave moving WIDTH-bit words.
// spi_clk, spi_mosi and spi_cs_n are synchronized into the clk domain and
// their edges detected there; spi_clk is never used as a clock.
//   clk, rst_n                 : system clock, synchronous active-low reset
//   spi_clk/spi_mosi/spi_cs_n  : asynchronous SPI slave inputs
//   spi_miso, spi_miso_oe      : serial out and its enable (CS asserted)
//   user_out/_valid/_ready     : received words, first-word-fall-through
//   user_in, user_in_ack       : next TX word, ack pulses when it is latched
//   csn_state/csn_rise/csn_fall: synchronized CS level and edge pulses
//   rx_overflow                : pulse when a completed word is dropped
// Build option: define SPI_WORD_CORE_RX_FIFO_EN for a FIFO_DEPTH-entry RX
// FIFO; otherwise the RX path is a single holding register.
module spi_word_core
  import spi_word_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CPOL       = 0,
  parameter int unsigned CPHA       = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_clk,
  input  logic             spi_mosi,
  input  logic             spi_cs_n,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic [WIDTH-1:0] user_out,
  output logic             user_out_valid,
  input  logic             user_out_ready,
  input  logic [WIDTH-1:0] user_in,
  output logic             user_in_ack,
  output logic             csn_state,
  output logic             csn_rise,
  output logic             csn_fall,
  output logic             rx_overflow
);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("spi_word_core: WIDTH must lie in 4..32");
  end
  if (!depth_legal(FIFO_DEPTH)) begin : g_bad_depth
    $error("spi_word_core: FIFO_DEPTH must be a power of two in 2..16");
  end

  localparam int unsigned  CW          = $clog2(WIDTH);
  localparam logic         IDLE_CLK    = (CPOL != 0);
  localparam logic         CPHA0       = (CPHA == 0);
  localparam sample_edge_e SAMPLE_EDGE = sample_edge_sel(CPOL, CPHA);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);

  logic [SYNC_STAGES-1:0] spi_clk_buf;
  logic [SYNC_STAGES-1:0] spi_mosi_buf;
  logic [SYNC_STAGES-1:0] spi_cs_buf;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   sample_edge;
  logic                   shift_edge;
  logic                   active;
  logic                   word_done;
  logic                   tx_load;
  logic                   csn_fall_d;
  logic                   push_pending;
  logic [CW-1:0]          bit_cnt;
  logic [WIDTH-1:0]       rx_shift;
  logic [WIDTH-1:0]       tx_word;

  assign sclk_s = spi_clk_buf[SYNC_STAGES-1];
  assign mosi_s = spi_mosi_buf[SYNC_STAGES-1];
  assign cs_s   = spi_cs_buf[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spi_clk_buf  <= {SYNC_STAGES{IDLE_CLK}};
      spi_mosi_buf <= '0;
      spi_cs_buf   <= '1;
    end else begin
      spi_clk_buf  <= {spi_clk_buf[SYNC_STAGES-2:0], spi_clk};
      spi_mosi_buf <= {spi_mosi_buf[SYNC_STAGES-2:0], spi_mosi};
      spi_cs_buf   <= {spi_cs_buf[SYNC_STAGES-2:0], spi_cs_n};
    end
  end

  assign sclk_rise   = sclk_s && !sclk_d;
  assign sclk_fall   = !sclk_s && sclk_d;
  assign sample_edge = (SAMPLE_EDGE == EDGE_RISE) ? sclk_rise : sclk_fall;
  assign shift_edge  = (SAMPLE_EDGE == EDGE_RISE) ? sclk_fall : sclk_rise;
  assign active      = !cs_s;
  assign word_done   = active && sample_edge && (bit_cnt == LAST_BIT);
  assign tx_load     = csn_fall || word_done;

  assign user_in_ack = tx_load;
  assign csn_state   = cs_s;
  assign spi_miso_oe = active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_d       <= IDLE_CLK;
      cs_d         <= 1'b1;
      csn_fall     <= 1'b0;
      csn_rise     <= 1'b0;
      csn_fall_d   <= 1'b0;
      push_pending <= 1'b0;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_word      <= '0;
      spi_miso     <= 1'b0;
    end else begin
      sclk_d       <= sclk_s;
      cs_d         <= cs_s;
      csn_fall     <= cs_d && !cs_s;
      csn_rise     <= !cs_d && cs_s;
      csn_fall_d   <= csn_fall;
      // rx_shift holds the full word one cycle after completion.
      push_pending <= word_done;

      if (!active) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end

      if (active && sample_edge) begin
        rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
      end

      if (tx_load) begin
        tx_word <= user_in;
      end

      // With CPHA=0 the first bit must be on the line before the first
      // clock edge, so the MSB is presented straight after the CS-fall load.
      if (CPHA0 && csn_fall_d) begin
        spi_miso <= tx_word[WIDTH-1];
      end else if (active && shift_edge) begin
        spi_miso <= tx_word[LAST_BIT - bit_cnt];
      end
    end
  end

`ifdef SPI_WORD_CORE_RX_FIFO_EN
  spi_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_pending),
    .push_data  (rx_shift),
    .pop_ready  (user_out_ready),
    .head_data  (user_out),
    .head_valid (user_out_valid),
    .overflow   (rx_overflow)
  );
`else
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;
  logic             hold_pop;

  assign hold_pop       = hold_valid && user_out_ready;
  assign user_out       = hold_data;
  assign user_out_valid = hold_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      rx_overflow <= 1'b0;
    end else begin
      rx_overflow <= push_pending && hold_valid && !hold_pop;
      if (push_pending && (!hold_valid || hold_pop)) begin
        hold_data  <= rx_shift;
        hold_valid <= 1'b1;
      end else if (hold_pop) begin
        hold_valid <= 1'b0;
      end
    end
  end
`endif

endmodule
